// File: rtl/wb_pipe_skid.sv
// Pipeline stage register with valid/ready handshake and a two-entry skid buffer.
// in_ready is taken straight from a flop, so it has no combinational path from out_ready.
module wb_pipe_skid #(
  parameter int DATA_W        = 104,
  parameter bit ZERO_ON_FLUSH = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_we,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_we,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic              m_valid, m_we, s_valid, s_we, ready_q;
  logic [DATA_W-1:0] m_data, s_data;

  logic              m_valid_n, m_we_n, s_valid_n, s_we_n;
  logic [DATA_W-1:0] m_data_n, s_data_n;
  logic              accept, consume;

  assign accept  = in_valid & ready_q;
  assign consume = m_valid & out_ready;

  // Next-state selection; flush wins over every datapath move.
  always_comb begin
    m_valid_n = m_valid;
    m_we_n    = m_we;
    m_data_n  = m_data;
    s_valid_n = s_valid;
    s_we_n    = s_we;
    s_data_n  = s_data;
    if (flush) begin
      m_valid_n = 1'b0;
      m_we_n    = 1'b0;
      s_valid_n = 1'b0;
      s_we_n    = 1'b0;
      if (ZERO_ON_FLUSH) begin
        m_data_n = '0;
        s_data_n = '0;
      end
    end else if (!m_valid || consume) begin
      if (s_valid) begin
        m_valid_n = 1'b1;
        m_we_n    = s_we;
        m_data_n  = s_data;
        s_valid_n = 1'b0;
        s_we_n    = 1'b0;
      end else if (accept) begin
        m_valid_n = 1'b1;
        m_we_n    = in_we;
        m_data_n  = in_data;
      end else begin
        m_valid_n = 1'b0;
        m_we_n    = 1'b0;
      end
    end else if (accept) begin
      s_valid_n = 1'b1;
      s_we_n    = in_we;
      s_data_n  = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      m_valid <= 1'b0;
      m_we    <= 1'b0;
      m_data  <= '0;
      s_valid <= 1'b0;
      s_we    <= 1'b0;
      s_data  <= '0;
      ready_q <= 1'b1;
    end else begin
      m_valid <= m_valid_n;
      m_we    <= m_we_n;
      m_data  <= m_data_n;
      s_valid <= s_valid_n;
      s_we    <= s_we_n;
      s_data  <= s_data_n;
      ready_q <= !s_valid_n;
    end
  end

  // m_we is cleared whenever main empties, so out_we is already 0 when out_valid is 0.
  assign in_ready  = ready_q;
  assign out_valid = m_valid;
  assign out_we    = m_we;
  assign out_data  = m_data;
  assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};

endmodule

// File: tb/tb_wb_pipe_skid.sv
// Self-checking bench for wb_pipe_skid: directed scenarios plus a random soak
// compared against a queue model of the held beats.
module tb_wb_pipe_skid;

  localparam int DW  = 104;
  localparam bit ZOF = 1'b1;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          in_we;
  logic [DW-1:0] in_data;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic          out_we;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;

  wb_pipe_skid #(.DATA_W(DW), .ZERO_ON_FLUSH(ZOF)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_we(in_we), .in_data(in_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_we(out_we), .out_data(out_data),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          we;
    logic [DW-1:0] data;
  } beat_t;

  beat_t model_q[$];
  bit    model_known = 1'b0;
  int    checks = 0;
  int    errors = 0;

  task automatic checkOutput(input string tag, input logic [DW:0] obs, input logic [DW:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Outputs are compared with the beats the model says are held: head of queue is main.
  task automatic compareModel();
    int n;
    n = model_q.size();
    checkOutput("out_valid", out_valid, (n > 0));
    checkOutput("occupancy", occupancy, n);
    checkOutput("in_ready", in_ready, (n < 2));
    checkOutput("out_we", out_we, (n > 0) ? model_q[0].we : 1'b0);
    if (n > 0) checkOutput("out_data", out_data, model_q[0].data);
  endtask

  // One clock cycle: drive, compare before the edge, advance the model across the edge.
  task automatic applyStimulus(input logic v, input logic we, input logic [DW-1:0] d,
                               input logic ordy, input logic fl, input logic r);
    bit acc;
    in_valid  = v;
    in_we     = we;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    rst       = r;
    @(negedge clk);
    if (model_known) compareModel();
    if (!r) begin
      model_q.delete();
      model_known = 1'b1;
    end else if (model_known) begin
      if (fl) begin
        model_q.delete();
      end else begin
        acc = v && (model_q.size() < 2);
        if (ordy && model_q.size() > 0) void'(model_q.pop_front());
        if (acc) model_q.push_back('{we, d});
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] randData();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[DW-1:0];
  endfunction

  initial begin
    // Reset held two cycles while upstream offers a beat
    applyStimulus(1'b1, 1'b1, 104'h77, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 104'h77, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_out_we", out_we, 1'b0);
    checkOutput("rst_out_data", out_data, '0);
    checkOutput("rst_in_ready", in_ready, 1'b1);
    checkOutput("rst_occupancy", occupancy, 2'd0);

    // Streaming at full throughput
    applyStimulus(1'b1, 1'b1, 104'h11, 1'b1, 1'b0, 1'b1);
    checkOutput("stream_d0", out_data, 104'h11);
    applyStimulus(1'b1, 1'b0, 104'h22, 1'b1, 1'b0, 1'b1);
    checkOutput("stream_d1", out_data, 104'h22);
    checkOutput("stream_we1", out_we, 1'b0);
    applyStimulus(1'b1, 1'b1, 104'h33, 1'b1, 1'b0, 1'b1);
    checkOutput("stream_d2", out_data, 104'h33);
    checkOutput("stream_ready", in_ready, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);

    // Backpressure fills main then skid
    applyStimulus(1'b1, 1'b1, 104'hA1, 1'b0, 1'b0, 1'b1);
    checkOutput("bp_occ1", occupancy, 2'd1);
    applyStimulus(1'b1, 1'b0, 104'hA2, 1'b0, 1'b0, 1'b1);
    checkOutput("bp_occ2", occupancy, 2'd2);
    checkOutput("bp_ready", in_ready, 1'b0);
    checkOutput("bp_hold", out_data, 104'hA1);
    applyStimulus(1'b1, 1'b0, 104'hEE, 1'b1, 1'b0, 1'b1);
    checkOutput("bp_second", out_data, 104'hA2);
    checkOutput("bp_ready_back", in_ready, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
    checkOutput("bp_empty", out_valid, 1'b0);

    // Flush with both entries full and a beat offered
    applyStimulus(1'b1, 1'b1, 104'hB1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 104'hB2, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 104'hBB, 1'b0, 1'b1, 1'b1);
    checkOutput("flush_valid", out_valid, 1'b0);
    checkOutput("flush_we", out_we, 1'b0);
    checkOutput("flush_occ", occupancy, 2'd0);
    checkOutput("flush_ready", in_ready, 1'b1);
    checkOutput("flush_zero", out_data, '0);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);

    // Reset while stalled with two beats held
    applyStimulus(1'b1, 1'b1, 104'hC1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 104'hC2, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("mrst_valid", out_valid, 1'b0);
    checkOutput("mrst_occ", occupancy, 2'd0);
    checkOutput("mrst_data", out_data, '0);
    checkOutput("mrst_ready", in_ready, 1'b1);
    applyStimulus(1'b1, 1'b1, 104'h5A, 1'b1, 1'b0, 1'b1);
    checkOutput("mrst_latency", out_data, 104'h5A);
    checkOutput("mrst_lat_valid", out_valid, 1'b1);

    // Random soak
    for (int i = 0; i < 10000; i++) begin
      applyStimulus(($urandom_range(0, 9) < 7), $urandom_range(0, 1), randData(),
                    $urandom_range(0, 1), ($urandom_range(0, 31) == 0), 1'b1);
    end
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_pipe_skid.md
# wb_pipe_skid

Parametrised pipeline-stage register with a valid/ready handshake and a two-entry skid buffer. It carries an arbitrary payload plus a register-write-enable bit between two pipeline stages, typically MEM→WB. Unlike a plain stage register, it lets the downstream stage stall without losing data. It also supports a synchronous flush that kills in-flight writes, and it keeps `in_ready` free of any combinational path from `out_ready`.

## Interface
- `DATA_W`, default 104: payload width in bits (e.g. readData 32 + aluOut 32 + pc 32 + regAddr 5 + regSrc 2 + spare).
- `ZERO_ON_FLUSH`, default 0: if 1, flush also clears both payload registers to 0; if 0, payload holds its value on flush.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous, active-low.
- `in_valid` input 1: upstream offers a beat.
- `in_ready` output 1: registered; block can accept a beat this cycle.
- `in_we` input 1: register-file write enable of the offered beat.
- `in_data` input DATA_W: payload of the offered beat.
- `flush` input 1: synchronous kill of all held beats.
- `out_valid` output 1: registered; main entry holds a beat.
- `out_ready` input 1: downstream consumes the beat this cycle.
- `out_we` output 1: registered; write enable of the main entry, forced 0 whenever `out_valid`=0.
- `out_data` output DATA_W: registered payload of the main entry.
- `occupancy` output 2: number of held beats, 0..2.

## Operation
- **State.** Main entry (`m_valid`, `m_we`, `m_data`) drives the outputs. Skid entry (`s_valid`, `s_we`, `s_data`) holds the overflow beat.
- **Handshake conditions.**
  - accept = `in_valid` & `in_ready`.
  - consume = `out_valid` & `out_ready`.
- **Datapath moves** (when not flushing):
  - main empty, accept: the beat goes to main.
  - main full, consume, skid empty, accept: the beat goes to main (pass-through, throughput 1 beat/cycle).
  - main full, no consume, accept: the beat goes to skid.
  - main full, consume, skid full: skid moves to main and skid empties. No accept is possible here, because `in_ready`=0.
  - main full, consume, no accept, skid empty: main empties.
- **Derived outputs.**
  - `in_ready` next = !(skid full next cycle).
  - `occupancy` = `m_valid` + `s_valid`.
  - Invariant: `s_valid`=1 implies `m_valid`=1.
- **Flush.**
  - Highest priority.
  - Clears `m_valid`, `s_valid`, `m_we`, `s_we`; also clears the payload if `ZERO_ON_FLUSH`=1.
  - A beat offered in the flush cycle is dropped, even if `in_ready`=1; upstream treats it as accepted-and-killed.
  - A beat consumed in the flush cycle still counts as delivered, because the outputs were valid during that cycle.
- **Reset.**
  - Overrides flush.
  - All valid/we flags and both payload registers go to 0.
  - `in_ready` goes to 1.
- **Payload transparency.** Payload and `in_we` are stored unmodified; the block never inspects the payload.

## Timing
- **Reset values:**
  - `out_valid`=0, `out_we`=0, `out_data`=0
  - `in_ready`=1, `occupancy`=0
- **Latency.** Accept at edge N puts the beat on the outputs after edge N; it is visible in cycle N+1.
- **Ready timing.**
  - `in_ready` falls in the cycle after the skid fills.
  - `in_ready` rises in the cycle after the skid drains.
  - Because `in_ready` is registered, at most one beat is ever in flight toward the skid, so overflow is impossible.
- **Output stability.** While `out_valid`=1 and `out_ready`=0, `out_data` and `out_we` stay stable until consumed or flushed.
- **Flush timing.** Flush at edge N gives `out_valid`=0, `occupancy`=0 and `in_ready`=1 in cycle N+1.
- **Reset mid-operation.** Any held beats are discarded; there is no partial state.

## Test plan
- **Reset.** Hold `rst`=0 for 2 cycles with `in_valid`=1 → `out_valid`=0, `out_we`=0, `out_data`=0, `in_ready`=1, `occupancy`=0.
- **Streaming.** `out_ready`=1; drive beats D0=0x11, D1=0x22, D2=0x33 on consecutive cycles with `in_we`=1,0,1 → outputs D0, D1, D2 one cycle later, back-to-back, with `out_we`=1,0,1 and `in_ready` constantly 1.
- **Backpressure.** `out_ready`=0; send 0xA1 then 0xA2 → `occupancy` 1 then 2 and `in_ready`=0, with `out_data` holding 0xA1. Then set `out_ready`=1 → 0xA1, then 0xA2 appear on consecutive cycles, and `in_ready` returns to 1 the cycle after the skid drains. No loss and no duplication.
- **Flush with full buffer.** With 2 beats held (we=1) and `in_valid`=1 (0xBB), pulse `flush` → next cycle `out_valid`=0, `out_we`=0, `occupancy`=0. 0xBB never appears. With `ZERO_ON_FLUSH`=1, `out_data`=0.
- **Random soak.** Randomise `in_valid`, `out_ready` and `flush` for 10k cycles against a queue scoreboard → outputs match the queue order, the queue is emptied on every flush, the invariants hold, and `out_we`=0 whenever `out_valid`=0.
- **Reset mid-stall.** Apply reset with `occupancy`=2 and `out_ready`=0 → next cycle all outputs are at their reset values, and the first beat sent afterwards appears with latency 1.
